// File: rtl/param_cift_yollu_ram_if.sv
// Port bundle for the two-write / two-read-port RAM: write, read, clear and status signals.
// The master drives requests; the RAM connects through the slave modport.
interface param_cift_yollu_ram_if #(
    parameter int VERI_GENISLIK  = 16,
    parameter int ADRES_GENISLIK = 4
);
    localparam int BE_GENISLIK = VERI_GENISLIK / 8;

    logic                      temizle;
    logic                      hazir;

    logic                      w_en1;
    logic [ADRES_GENISLIK-1:0] w_addr1;
    logic [BE_GENISLIK-1:0]    w_be1;
    logic [VERI_GENISLIK-1:0]  w_veri1;
    logic                      w_en2;
    logic [ADRES_GENISLIK-1:0] w_addr2;
    logic [BE_GENISLIK-1:0]    w_be2;
    logic [VERI_GENISLIK-1:0]  w_veri2;

    logic                      r_en1;
    logic [ADRES_GENISLIK-1:0] r_addr1;
    logic [VERI_GENISLIK-1:0]  r_veri1;
    logic                      r_gecerli1;
    logic                      r_en2;
    logic [ADRES_GENISLIK-1:0] r_addr2;
    logic [VERI_GENISLIK-1:0]  r_veri2;
    logic                      r_gecerli2;

    logic                      carpisma;

    modport slave (
        input  temizle,
        input  w_en1, w_addr1, w_be1, w_veri1,
        input  w_en2, w_addr2, w_be2, w_veri2,
        input  r_en1, r_addr1, r_en2, r_addr2,
        output hazir, r_veri1, r_gecerli1, r_veri2, r_gecerli2, carpisma
    );

    modport master (
        output temizle,
        output w_en1, w_addr1, w_be1, w_veri1,
        output w_en2, w_addr2, w_be2, w_veri2,
        output r_en1, r_addr1, r_en2, r_addr2,
        input  hazir, r_veri1, r_gecerli1, r_veri2, r_gecerli2, carpisma
    );
endinterface

// File: rtl/param_cift_yollu_ram.sv
// Parametrised 2W/2R synchronous RAM with byte enables, port-1 collision priority,
// selectable read-during-write behaviour and a clear FSM that zeroes the array.
module param_cift_yollu_ram #(
    parameter int VERI_GENISLIK  = 16,
    parameter int ADRES_GENISLIK = 4,
    parameter int OKUMA_MODU     = 0,
    parameter int BE_GENISLIK    = VERI_GENISLIK / 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    param_cift_yollu_ram_if.slave  bus
);
    localparam int DERINLIK = 2 ** ADRES_GENISLIK;
    localparam logic [ADRES_GENISLIK-1:0] SON_ADRES = ADRES_GENISLIK'(DERINLIK - 1);

    typedef enum logic [0:0] {
        TEMIZLE = 1'b0,
        HAZIR   = 1'b1
    } durum_t;

    // Replace the enabled bytes of a word with new data.
    function automatic logic [VERI_GENISLIK-1:0] bayt_birlestir(
        input logic [VERI_GENISLIK-1:0] eski,
        input logic [VERI_GENISLIK-1:0] yeni,
        input logic [BE_GENISLIK-1:0]   be
    );
        logic [VERI_GENISLIK-1:0] sonuc;
        sonuc = eski;
        for (int i = 0; i < BE_GENISLIK; i++) begin
            sonuc[8*i +: 8] = be[i] ? yeni[8*i +: 8] : eski[8*i +: 8];
        end
        return sonuc;
    endfunction

    logic [VERI_GENISLIK-1:0]  r_mem [DERINLIK];
    durum_t                    r_durum;
    logic [ADRES_GENISLIK-1:0] r_sayac;
    logic                      r_hazir;
    logic [VERI_GENISLIK-1:0]  r_oku_veri1;
    logic [VERI_GENISLIK-1:0]  r_oku_veri2;
    logic                      r_oku_gecerli1;
    logic                      r_oku_gecerli2;
    logic                      r_carpisma;

    logic                      w_calisiyor;
    logic                      w_yaz1;
    logic                      w_yaz2;
    logic                      w_carpisma;
    logic [VERI_GENISLIK-1:0]  w_kelime1;
    logic [VERI_GENISLIK-1:0]  w_kelime2;
    logic [VERI_GENISLIK-1:0]  w_okuma1;
    logic [VERI_GENISLIK-1:0]  w_okuma2;

    assign w_calisiyor = (r_durum == HAZIR);
    assign w_yaz1      = w_calisiyor && bus.w_en1;
    assign w_yaz2      = w_calisiyor && bus.w_en2;
    assign w_carpisma  = w_yaz1 && w_yaz2 && (bus.w_addr1 == bus.w_addr2);

    // Post-write words; on a collision both ports carry the same merged word, port 1 applied last.
    always_comb begin
        w_kelime1 = r_mem[bus.w_addr1];
        w_kelime2 = r_mem[bus.w_addr2];
        if (w_carpisma) begin
            w_kelime1 = bayt_birlestir(bayt_birlestir(r_mem[bus.w_addr1], bus.w_veri2, bus.w_be2),
                                       bus.w_veri1, bus.w_be1);
            w_kelime2 = w_kelime1;
        end else begin
            w_kelime1 = bayt_birlestir(r_mem[bus.w_addr1], bus.w_veri1, bus.w_be1);
            w_kelime2 = bayt_birlestir(r_mem[bus.w_addr2], bus.w_veri2, bus.w_be2);
        end
    end

    // Read data source, forwarding the post-write word in write-through mode.
    always_comb begin
        w_okuma1 = r_mem[bus.r_addr1];
        w_okuma2 = r_mem[bus.r_addr2];
        if ((OKUMA_MODU != 0) && w_yaz1 && (bus.w_addr1 == bus.r_addr1)) begin
            w_okuma1 = w_kelime1;
        end else if ((OKUMA_MODU != 0) && w_yaz2 && (bus.w_addr2 == bus.r_addr1)) begin
            w_okuma1 = w_kelime2;
        end else begin
            w_okuma1 = r_mem[bus.r_addr1];
        end
        if ((OKUMA_MODU != 0) && w_yaz1 && (bus.w_addr1 == bus.r_addr2)) begin
            w_okuma2 = w_kelime1;
        end else if ((OKUMA_MODU != 0) && w_yaz2 && (bus.w_addr2 == bus.r_addr2)) begin
            w_okuma2 = w_kelime2;
        end else begin
            w_okuma2 = r_mem[bus.r_addr2];
        end
    end

    // Array storage: clear sweep or port writes; left unreset so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (r_durum == TEMIZLE) begin
            r_mem[r_sayac] <= '0;
        end else begin
            if (w_yaz1) begin
                r_mem[bus.w_addr1] <= w_kelime1;
            end
            if (w_yaz2) begin
                r_mem[bus.w_addr2] <= w_kelime2;
            end
        end
    end

    // Clear/ready FSM with registered read, valid, collision and ready outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_durum        <= TEMIZLE;
            r_sayac        <= '0;
            r_hazir        <= 1'b0;
            r_oku_veri1    <= '0;
            r_oku_veri2    <= '0;
            r_oku_gecerli1 <= 1'b0;
            r_oku_gecerli2 <= 1'b0;
            r_carpisma     <= 1'b0;
        end else begin
            case (r_durum)
                TEMIZLE: begin
                    r_oku_gecerli1 <= 1'b0;
                    r_oku_gecerli2 <= 1'b0;
                    r_carpisma     <= 1'b0;
                    if (r_sayac == SON_ADRES) begin
                        r_durum <= HAZIR;
                        r_hazir <= 1'b1;
                        r_sayac <= '0;
                    end else begin
                        r_sayac <= r_sayac + ADRES_GENISLIK'(1);
                    end
                end
                HAZIR: begin
                    r_carpisma     <= w_carpisma;
                    r_oku_gecerli1 <= bus.r_en1;
                    r_oku_gecerli2 <= bus.r_en2;
                    if (bus.r_en1) begin
                        r_oku_veri1 <= w_okuma1;
                    end
                    if (bus.r_en2) begin
                        r_oku_veri2 <= w_okuma2;
                    end
                    if (bus.temizle) begin
                        r_durum <= TEMIZLE;
                        r_sayac <= '0;
                        r_hazir <= 1'b0;
                    end
                end
                default: begin
                    r_durum <= TEMIZLE;
                    r_sayac <= '0;
                    r_hazir <= 1'b0;
                end
            endcase
        end
    end

    assign bus.hazir      = r_hazir;
    assign bus.r_veri1    = r_oku_veri1;
    assign bus.r_veri2    = r_oku_veri2;
    assign bus.r_gecerli1 = r_oku_gecerli1;
    assign bus.r_gecerli2 = r_oku_gecerli2;
    assign bus.carpisma   = r_carpisma;
endmodule

// File: tb/tb_param_cift_yollu_ram.sv
// Bench for param_cift_yollu_ram: a 16x16 old-data instance and a 64x32 write-through
// instance share one stimulus stream and are compared against a word-array model.
module tb_param_cift_yollu_ram;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        temizle;
    logic        w_en1, w_en2, r_en1, r_en2;
    logic [5:0]  w_a1, w_a2, r_a1, r_a2;
    logic [3:0]  w_be1, w_be2;
    logic [31:0] w_d1, w_d2;

    param_cift_yollu_ram_if #(.VERI_GENISLIK(16), .ADRES_GENISLIK(4)) if_a ();
    param_cift_yollu_ram_if #(.VERI_GENISLIK(32), .ADRES_GENISLIK(6)) if_b ();

    param_cift_yollu_ram #(.VERI_GENISLIK(16), .ADRES_GENISLIK(4), .OKUMA_MODU(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(if_a));
    param_cift_yollu_ram #(.VERI_GENISLIK(32), .ADRES_GENISLIK(6), .OKUMA_MODU(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(if_b));

    assign if_a.temizle = temizle;
    assign if_a.w_en1 = w_en1;  assign if_a.w_addr1 = w_a1[3:0];
    assign if_a.w_be1 = w_be1[1:0]; assign if_a.w_veri1 = w_d1[15:0];
    assign if_a.w_en2 = w_en2;  assign if_a.w_addr2 = w_a2[3:0];
    assign if_a.w_be2 = w_be2[1:0]; assign if_a.w_veri2 = w_d2[15:0];
    assign if_a.r_en1 = r_en1;  assign if_a.r_addr1 = r_a1[3:0];
    assign if_a.r_en2 = r_en2;  assign if_a.r_addr2 = r_a2[3:0];

    assign if_b.temizle = temizle;
    assign if_b.w_en1 = w_en1;  assign if_b.w_addr1 = w_a1;
    assign if_b.w_be1 = w_be1;  assign if_b.w_veri1 = w_d1;
    assign if_b.w_en2 = w_en2;  assign if_b.w_addr2 = w_a2;
    assign if_b.w_be2 = w_be2;  assign if_b.w_veri2 = w_d2;
    assign if_b.r_en1 = r_en1;  assign if_b.r_addr1 = r_a1;
    assign if_b.r_en2 = r_en2;  assign if_b.r_addr2 = r_a2;

    initial forever #5 clk = ~clk;

    // Reference model: word arrays, cycles of clearing left, expected outputs (index 0 = A, 1 = B).
    logic [31:0] m [2][64];
    int          kalan [2];
    logic [31:0] e_veri [2][2];
    logic        e_gec [2][2];
    logic        e_carp [2];
    logic        e_hazir [2];

    int n_kontrol = 0;
    int n_hata = 0;

    task automatic kontrol_et(input string etiket, input logic [31:0] gozlenen, input logic [31:0] beklenen);
        n_kontrol++;
        if (gozlenen !== beklenen) begin
            n_hata++;
            $display("FAIL %s: observed %h expected %h at %0t", etiket, gozlenen, beklenen, $time);
        end
    endtask

    task automatic model_adim(input int k);
        int D, BE, a1, a2, ra1, ra2;
        logic [31:0] eski [64];
        D  = (k == 0) ? 16 : 64;
        BE = (k == 0) ? 2 : 4;
        if (rst_n !== 1'b1) begin
            kalan[k] = D;
            e_hazir[k] = 1'b0; e_carp[k] = 1'b0;
            e_gec[k][0] = 1'b0; e_gec[k][1] = 1'b0;
            e_veri[k][0] = 32'd0; e_veri[k][1] = 32'd0;
        end else if (kalan[k] > 0) begin
            m[k][D - kalan[k]] = 32'd0;
            kalan[k]--;
            e_hazir[k] = (kalan[k] == 0);
            e_gec[k][0] = 1'b0; e_gec[k][1] = 1'b0;
            e_carp[k] = 1'b0;
        end else begin
            a1 = int'(w_a1) % D;  a2 = int'(w_a2) % D;
            ra1 = int'(r_a1) % D; ra2 = int'(r_a2) % D;
            for (int i = 0; i < 64; i++) eski[i] = m[k][i];
            for (int b = 0; b < BE; b++) if (w_en2 && w_be2[b]) m[k][a2][8*b +: 8] = w_d2[8*b +: 8];
            for (int b = 0; b < BE; b++) if (w_en1 && w_be1[b]) m[k][a1][8*b +: 8] = w_d1[8*b +: 8];
            if (r_en1) e_veri[k][0] = (k == 1) ? m[k][ra1] : eski[ra1];
            if (r_en2) e_veri[k][1] = (k == 1) ? m[k][ra2] : eski[ra2];
            e_gec[k][0] = r_en1;
            e_gec[k][1] = r_en2;
            e_carp[k] = w_en1 && w_en2 && (a1 == a2);
            e_hazir[k] = !temizle;
            if (temizle) kalan[k] = D;
        end
    endtask

    task automatic kontrol_hepsi();
        kontrol_et("A hazir",    32'(if_a.hazir),      32'(e_hazir[0]));
        kontrol_et("A carpisma", 32'(if_a.carpisma),   32'(e_carp[0]));
        kontrol_et("A gecerli1", 32'(if_a.r_gecerli1), 32'(e_gec[0][0]));
        kontrol_et("A gecerli2", 32'(if_a.r_gecerli2), 32'(e_gec[0][1]));
        kontrol_et("A veri1",    32'(if_a.r_veri1),    {16'd0, e_veri[0][0][15:0]});
        kontrol_et("A veri2",    32'(if_a.r_veri2),    {16'd0, e_veri[0][1][15:0]});
        kontrol_et("B hazir",    32'(if_b.hazir),      32'(e_hazir[1]));
        kontrol_et("B carpisma", 32'(if_b.carpisma),   32'(e_carp[1]));
        kontrol_et("B gecerli1", 32'(if_b.r_gecerli1), 32'(e_gec[1][0]));
        kontrol_et("B gecerli2", 32'(if_b.r_gecerli2), 32'(e_gec[1][1]));
        kontrol_et("B veri1",    if_b.r_veri1,         e_veri[1][0]);
        kontrol_et("B veri2",    if_b.r_veri2,         e_veri[1][1]);
    endtask

    task automatic cevrim();
        model_adim(0);
        model_adim(1);
        @(posedge clk);
        @(negedge clk);
        kontrol_hepsi();
    endtask

    task automatic bosta();
        temizle = 1'b0; w_en1 = 1'b0; w_en2 = 1'b0; r_en1 = 1'b0; r_en2 = 1'b0;
        w_a1 = 6'd0; w_a2 = 6'd0; r_a1 = 6'd0; r_a2 = 6'd0;
        w_be1 = 4'd0; w_be2 = 4'd0; w_d1 = 32'd0; w_d2 = 32'd0;
    endtask

    task automatic rastgele(input bit temizle_izin);
        w_en1 = 1'($urandom);  w_a1 = 6'($urandom_range(0, 63));
        w_be1 = 4'($urandom);  w_d1 = $urandom;
        w_en2 = 1'($urandom);  w_a2 = ($urandom_range(0, 2) == 0) ? w_a1 : 6'($urandom_range(0, 63));
        w_be2 = 4'($urandom);  w_d2 = $urandom;
        r_en1 = 1'($urandom);  r_a1 = ($urandom_range(0, 1) == 0) ? w_a1 : 6'($urandom_range(0, 63));
        r_en2 = 1'($urandom);  r_a2 = ($urandom_range(0, 1) == 0) ? w_a2 : r_a1;
        temizle = temizle_izin && ($urandom_range(0, 199) == 0);
    endtask

    // Hold reset two cycles, release, and measure cycles until each instance reports ready.
    task automatic sifirla_ve_olc(input string etiket);
        int n_a, n_b;
        bosta();
        rst_n = 1'b0;
        cevrim();
        cevrim();
        rst_n = 1'b1;
        n_a = -1; n_b = -1;
        for (int n = 1; n <= 200 && (n_a < 0 || n_b < 0); n++) begin
            cevrim();
            if (n_a < 0 && if_a.hazir === 1'b1) n_a = n;
            if (n_b < 0 && if_b.hazir === 1'b1) n_b = n;
        end
        kontrol_et({etiket, " A init cycles"}, 32'(n_a), 32'd16);
        kontrol_et({etiket, " B init cycles"}, 32'(n_b), 32'd64);
    endtask

    task automatic tumunu_oku_sifir(input string etiket);
        bosta();
        for (int a = 0; a < 64; a++) begin
            r_en1 = 1'b1; r_a1 = 6'(a);
            r_en2 = 1'b1; r_a2 = 6'(63 - a);
            cevrim();
            kontrol_et({etiket, " B zero"}, if_b.r_veri1, 32'd0);
            if (a < 16) kontrol_et({etiket, " A zero"}, 32'(if_a.r_veri1), 32'd0);
        end
        bosta();
    endtask

    task automatic doldur();
        bosta();
        for (int a = 0; a < 64; a++) begin
            w_en1 = 1'b1; w_a1 = 6'(a); w_be1 = 4'hF; w_d1 = $urandom | 32'h0101_0101;
            cevrim();
        end
        bosta();
    endtask

    initial begin
        int n_a;
        bosta();
        cevrim();
        sifirla_ve_olc("power-up");

        // Garbage in the array, then a fresh reset must clear it.
        doldur();
        sifirla_ve_olc("reset");
        tumunu_oku_sifir("after reset");

        // Byte enables.
        w_en1 = 1'b1; w_a1 = 6'd3; w_be1 = 4'b0011; w_d1 = 32'h0000_A5A5; cevrim();
        w_be1 = 4'b0010; w_d1 = 32'h0000_3C00; cevrim();
        bosta(); r_en1 = 1'b1; r_a1 = 6'd3; cevrim();
        kontrol_et("be A", 32'(if_a.r_veri1), 32'h0000_3CA5);
        kontrol_et("be B", if_b.r_veri1, 32'h0000_3CA5);

        // Write-write collision, full overlap then partial.
        bosta();
        w_en1 = 1'b1; w_a1 = 6'd7; w_be1 = 4'b0011; w_d1 = 32'h0000_1111;
        w_en2 = 1'b1; w_a2 = 6'd7; w_be2 = 4'b0011; w_d2 = 32'h0000_2222;
        cevrim();
        kontrol_et("collide flag A", 32'(if_a.carpisma), 32'd1);
        bosta(); r_en1 = 1'b1; r_a1 = 6'd7; cevrim();
        kontrol_et("collide clears A", 32'(if_a.carpisma), 32'd0);
        kontrol_et("collide full A", 32'(if_a.r_veri1), 32'h0000_1111);
        bosta();
        w_en1 = 1'b1; w_a1 = 6'd7; w_be1 = 4'b0001; w_d1 = 32'h0000_1111;
        w_en2 = 1'b1; w_a2 = 6'd7; w_be2 = 4'b0011; w_d2 = 32'h0000_2222;
        cevrim();
        bosta(); r_en1 = 1'b1; r_a1 = 6'd7; cevrim();
        kontrol_et("collide partial A", 32'(if_a.r_veri1), 32'h0000_2211);
        kontrol_et("collide partial B", if_b.r_veri1, 32'h0000_2211);

        // Read during write on the same address.
        bosta(); w_en1 = 1'b1; w_a1 = 6'd5; w_be1 = 4'hF; w_d1 = 32'h0000_0001; cevrim();
        w_d1 = 32'h0000_BEEF; r_en1 = 1'b1; r_a1 = 6'd5; cevrim();
        kontrol_et("rdw old A", 32'(if_a.r_veri1), 32'h0000_0001);
        kontrol_et("rdw new B", if_b.r_veri1, 32'h0000_BEEF);

        // Clear request with traffic during the window.
        doldur();
        temizle = 1'b1; cevrim();
        temizle = 1'b0;
        n_a = -1;
        for (int n = 1; n <= 64; n++) begin
            if (n < 16) rastgele(1'b0); else bosta();
            cevrim();
            if (n_a < 0 && if_a.hazir === 1'b1) n_a = n;
        end
        kontrol_et("clear A low cycles", 32'(n_a), 32'd16);
        kontrol_et("clear B ready", 32'(if_b.hazir), 32'd1);
        tumunu_oku_sifir("after clear");

        // Single byte lane of the wide instance.
        w_en1 = 1'b1; w_a1 = 6'd9; w_be1 = 4'b0100; w_d1 = 32'hDEAD_BEEF; cevrim();
        bosta(); r_en1 = 1'b1; r_a1 = 6'd9; cevrim();
        kontrol_et("lane B", if_b.r_veri1, 32'h00AD_0000);
        kontrol_et("lane A no-op", 32'(if_a.r_veri1), 32'h0000_0000);

        // Reset in the middle of a clear restarts it.
        bosta(); temizle = 1'b1; cevrim();
        bosta();
        for (int n = 0; n < 5; n++) cevrim();
        sifirla_ve_olc("mid-clear reset");

        // Randomised traffic, with occasional clear requests.
        for (int n = 0; n < 1500; n++) begin
            rastgele(1'b1);
            cevrim();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_kontrol, n_hata);
        $finish;
    end
endmodule
